uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  - Downstream stage of the SEND control path: consumes snd_flag (send strobe) and transmits one byte on the UART TX line.
//  - Latches the byte on the strobe and sends an 8N1 frame, LSB first: start, 8 data bits, [parity], stop.
//  - Reports busy, done and overrun status back to the CPU-side UART block.
// PARAMETERS
//  CLKS_PER_BIT  5208  clock cycles per bit time (50 MHz / 9600 baud); must be >= 2
//  PARITY_ODD    0     0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  snd_flag    in   1  send request from send_control; level, may stay high for several cycles
//  tx_data     in   8  byte to send; sampled only in the start cycle
//  tx          out  1  serial line, idle high
//  tx_busy     out  1  high from the first cycle of the start bit until the cycle after the stop bit ends
//  tx_done     out  1  one-cycle pulse in the cycle after the stop bit completes
//  tx_overrun  out  1  sticky; set when a send request arrives while busy; cleared only by reset
// BEHAVIOUR
//  - Reset (async) values: tx=1, tx_busy=0, tx_done=0, tx_overrun=0, state=IDLE, baud counter=0, bit index=0, snd_flag edge register=0.
//  - Reset mid-frame: the frame is aborted immediately and tx returns to 1. Nothing resumes after reset.
//  - Send request: a rising edge of snd_flag, i.e. snd_flag=1 in this cycle and snd_flag=0 in the previous registered sample.
//    A level held high counts as one request only.
//  - Request in IDLE: on that clock edge tx_data is latched into the shift register and the state becomes START.
//    tx=0 and tx_busy=1 are visible in the next cycle (1-cycle latency; all outputs are registered).
//  - Request in any other state: the request is dropped, the frame in progress is unaffected, and tx_overrun is set.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - Each state drives its bit for exactly CLKS_PER_BIT cycles.
//    - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit transition.
//    - Counter width is $clog2(CLKS_PER_BIT).
//  - DATA: 8 bits, bit index 0..7, LSB first. DATA is left once bit 7 has been held for its full time.
//  - STOP: tx=1 for one bit time. On its last cycle the state returns to IDLE, tx_busy goes to 0, and tx_done=1 for exactly one cycle.
//  - Back-to-back frames: a new rising edge of snd_flag in the tx_done cycle is accepted, because the state is already IDLE.
//    The next start bit then follows the stop bit with no idle gap beyond the 1-cycle latency.
//  - Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
//  - tx_data changing during a frame has no effect.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state is inserted between DATA and STOP.
//   - Parity bit = ^latched_byte ^ PARITY_ODD.
//  UART_TX_PARITY_EN undefined:
//   - No PARITY state; DATA goes directly to STOP.
//   - PARITY_ODD is ignored.
//   - Frame is 8N1.
// STRUCTURE
//  - Shared header uart_defs.vh holds:
//    - the state encodings (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
//    - the default CLKS_PER_BIT;
//    - UART_DATA_BITS=8.
//  - uart_defs.vh is shared with the receive side.
//  - One sub-module: uart_baud_gen.
//    - Holds the bit-time counter with a clear input.
//    - Asserts a one-cycle bit_end at count CLKS_PER_BIT-1.
//    - Is reused by the RX block.
//  - The FSM, shift register, edge detector and status flags live in the top module.
// TESTING (simulate with CLKS_PER_BIT=4)
//  1. Reset mid-frame: assert reset during DATA bit 3 -> tx=1, tx_busy=0 in the same cycle; no tx_done; a later send works normally.
//  2. Single byte 8'hA5, snd_flag high for 1 cycle:
//     - tx reads 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles;
//     - tx_busy is high for 40 cycles;
//     - tx_done is high for 1 cycle; tx_overrun=0.
//  3. Held strobe: snd_flag high for 30 cycles with 8'h3C -> exactly one frame; tx_overrun stays 0.
//  4. Overrun: send 8'h00, then pulse snd_flag again at cycle 15 with 8'hFF -> the frame stays 8'h00 unchanged; tx_overrun=1 until reset.
//  5. Back-to-back: 8'h01, then 8'h80 with its snd_flag edge in the tx_done cycle -> the second start bit begins 1 cycle after the first stop bit ends.
//  6. With UART_TX_PARITY_EN, PARITY_ODD=0:
//     - 8'h07 -> parity bit 1; frame is 44 cycles.
//     - With PARITY_ODD=1 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: state encodings, default bit time, data width and the parity helper.
// Used by the transmit serializer and the bit-time generator; the receive side imports it too.
package uart_tx_serializer_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity when odd=0, odd parity when odd=1
    function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// uart_baud_gen: bit-time counter with synchronous clear; bit_end marks the last cycle of each bit.
// Shared between the TX and RX blocks.
module uart_baud_gen
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Counts 0..CLKS_PER_BIT-1 and wraps; held at zero while cleared
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign bit_end = (cnt_r == LAST_CNT) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: sends one byte per snd_flag rising edge as start, 8 data bits LSB first, [parity], stop.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      snd_flag,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      tx_overrun
);

`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

    tx_state_e                 state_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [IDX_W-1:0]          bit_idx_r;
    logic                      snd_prev_r;
    logic                      parity_r;
    logic                      tx_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      overrun_r;

    logic req_s;
    logic bit_end_s;
    logic baud_clear_s;

    // A held level only counts once: request is the rising edge against last cycle's sample
    assign req_s        = snd_flag && !snd_prev_r;
    assign baud_clear_s = (state_r == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (baud_clear_s),
        .bit_end(bit_end_s)
    );

    // Frame sequencer with shift register, edge detector and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= {UART_DATA_BITS{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            snd_prev_r <= 1'b0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            snd_prev_r <= snd_flag;
            done_r     <= 1'b0;
            if (req_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        shift_r   <= tx_data;
                        parity_r  <= calc_parity(tx_data, PARITY_ODD != 0);
                        bit_idx_r <= {IDX_W{1'b0}};
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
                        bit_idx_r <= {IDX_W{1'b0}};
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_BIT) begin
                            bit_idx_r <= {IDX_W{1'b0}};
                            if (HAS_PARITY) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Last stop cycle: back to IDLE so a request in the done cycle is accepted
                    if (bit_end_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign tx_busy    = busy_r;
    assign tx_done    = done_r;
    assign tx_overrun = overrun_r;

endmodule
